// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scan controller.
// Row decode is active-low: exactly one low bit yields a valid row index.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } kp_state_e;

  localparam int KEY_CODE_W = 4;
  localparam int CNT_W      = 8;

  function automatic logic [2:0] row_onehot_low_to_idx(input logic [3:0] row);
    logic [2:0] res;
    case (row)
      4'b1110: res = {1'b1, 2'd0};
      4'b1101: res = {1'b1, 2'd1};
      4'b1011: res = {1'b1, 2'd2};
      4'b0111: res = {1'b1, 2'd3};
      default: res = {1'b0, 2'd0};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/keypad_scan_controller_if.sv
// Key-event handshake between the scan controller (master) and the downstream decoder (slave).
interface keypad_scan_controller_if;

  logic [keypad_pkg::KEY_CODE_W-1:0] key_code;
  logic                              key_valid;
  logic                              key_ready;

  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);

endinterface

// File: rtl/key_event_fifo.sv
// First-word-fall-through key-event FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle, otherwise it is dropped and flagged.
module key_event_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [WIDTH-1:0] dout_o,
  output logic             overflow_pulse_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full_o           = (count_q == CNT_MAX);
  assign empty_o          = (count_q == '0);
  assign dout_o           = mem_q[rd_ptr_q];
  assign do_pop_s         = pop_i && !empty_o;
  assign do_push_s        = push_i && (!full_o || do_pop_s);
  assign overflow_pulse_o = push_i && full_o && !do_pop_s;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= din_i;
      end
    end
  end

endmodule

// File: rtl/keypad_scan_controller.sv
// 4x4 keypad sequencer: column ring, press/release debounce, ghost rejection and
// a small event FIFO holding {row_idx, col_idx} for each debounced press.
module keypad_scan_controller
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 8,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                            newClock,
  input  logic                            reset_n,
  input  logic [3:0]                      ROW,
  output logic [3:0]                      COL,
  keypad_scan_controller_if.master        key_if,
  output logic                            key_held,
  output logic                            ghost,
  output logic                            overflow
);

  localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEBOUNCE_SCANS);

  kp_state_e              state_q, state_d;
  logic [1:0]             col_q, col_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc_s;
  logic [3:0]             cand_q, cand_d;
  logic                   overflow_q, overflow_d;
  logic [2:0]             row_dec_s;
  logic                   row_idle_s, row_single_s;
  logic                   push_s, pop_s;
  logic                   fifo_full_s, fifo_empty_s, fifo_ovf_s;
  logic [KEY_CODE_W-1:0]  push_code_s, head_code_s;

  assign row_dec_s    = row_onehot_low_to_idx(ROW);
  assign row_idle_s   = (ROW == 4'hF);
  assign row_single_s = row_dec_s[2];
  assign cnt_inc_s    = cnt_q + 8'd1;
  assign push_code_s  = {row_dec_s[1:0], col_q};

  // State, column, debounce counter and sticky overflow registers.
  always_ff @(posedge newClock) begin
    if (!reset_n) begin
      state_q    <= SCAN;
      col_q      <= 2'd0;
      cnt_q      <= 8'd0;
      cand_q     <= 4'hF;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = 8'd0;
    cand_d  = cand_q;
    push_s  = 1'b0;
    case (state_q)
      SCAN: begin
        if (row_idle_s) begin
          col_d = col_q + 2'd1;
        end else if (row_single_s) begin
          cand_d  = ROW;
          cnt_d   = 8'd1;
          state_d = DEB_PRESS;
        end else begin
          state_d = HELD;
        end
      end
      DEB_PRESS: begin
        if (ROW != cand_q) begin
          state_d = SCAN;
        end else if (cnt_inc_s == DEB_CNT) begin
          push_s  = 1'b1;
          state_d = HELD;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      HELD: begin
        if (row_idle_s) begin
          cnt_d   = 8'd1;
          state_d = DEB_REL;
        end else begin
          state_d = HELD;
        end
      end
      DEB_REL: begin
        // Any low row during release debounce is bounce: fall back to HELD.
        if (!row_idle_s) begin
          state_d = HELD;
        end else if (cnt_inc_s == DEB_CNT) begin
          col_d   = col_q + 2'd1;
          state_d = SCAN;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        state_d = SCAN;
      end
    endcase
  end

  always_comb begin
    COL        = 4'hF;
    COL[col_q] = 1'b0;
    ghost      = (state_q == SCAN) && !row_idle_s && !row_single_s;
    case (state_q)
      HELD, DEB_REL: key_held = 1'b1;
      default:       key_held = 1'b0;
    endcase
  end

  assign overflow_d = overflow_q | (fifo_ovf_s & fifo_full_s);
  assign overflow   = overflow_q;

  assign pop_s            = key_if.key_valid && key_if.key_ready;
  assign key_if.key_valid = !fifo_empty_s;
  assign key_if.key_code  = head_code_s;

  key_event_fifo #(
    .WIDTH (KEY_CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i            (newClock),
    .rst_ni           (reset_n),
    .push_i           (push_s),
    .din_i            (push_code_s),
    .full_o           (fifo_full_s),
    .pop_i            (pop_s),
    .empty_o          (fifo_empty_s),
    .dout_o           (head_code_s),
    .overflow_pulse_o (fifo_ovf_s)
  );

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Randomised bench for keypad_scan_controller: a behavioural keypad drives ROW and a
// run-length reference model predicts every output each cycle.
module tb_keypad_scan_controller;

  localparam int DEB   = 8;
  localparam int DEPTH = 4;

  logic       newClock = 1'b0;
  logic       reset_n;
  logic [3:0] ROW;
  logic [3:0] COL;
  logic       key_held, ghost, overflow;

  keypad_scan_controller_if kif();

  keypad_scan_controller #(.DEBOUNCE_SCANS(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .newClock (newClock),
    .reset_n  (reset_n),
    .ROW      (ROW),
    .COL      (COL),
    .key_if   (kif),
    .key_held (key_held),
    .ghost    (ghost),
    .overflow (overflow)
  );

  always #5 newClock = ~newClock;

  int n_vec = 0;
  int n_err = 0;

  // keys[r*4+c] = 1 when the switch at row r, column c is closed
  logic [15:0] keys = 16'h0;
  bit          rdy_rand = 0;
  bit          rdy_on_push = 0;

  // reference model
  int         m_col;
  int         m_run;
  bit         m_down;
  logic [3:0] m_cand;
  logic [3:0] m_q[$];
  bit         m_ovf;
  bit         m_fresh;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] rows_for(input int col);
    logic [3:0] r = 4'hF;
    for (int rr = 0; rr < 4; rr++) begin
      if (keys[rr*4+col]) r[rr] = 1'b0;
    end
    return r;
  endfunction

  function automatic bit will_push();
    return !m_down && (m_run == DEB - 1) && (ROW == m_cand);
  endfunction

  task automatic model_reset();
    m_col = 0; m_run = 0; m_down = 0; m_cand = 4'hF;
    m_q.delete(); m_ovf = 0; m_fresh = 1;
  endtask

  task automatic check_outputs();
    logic [3:0] ecol;
    bit         eghost;
    ecol = 4'hF;
    ecol[m_col] = 1'b0;
    eghost = !m_down && (m_run == 0) && ($countones(~ROW) > 1);
    check_eq("col", COL, ecol);
    check_eq("key_valid", {3'b000, kif.key_valid}, {3'b000, m_q.size() != 0});
    if (m_q.size() != 0) check_eq("key_code", kif.key_code, m_q[0]);
    else if (m_fresh) check_eq("key_code_rst", kif.key_code, 4'h0);
    check_eq("key_held", {3'b000, key_held}, {3'b000, m_down});
    check_eq("ghost", {3'b000, ghost}, {3'b000, eghost});
    check_eq("overflow", {3'b000, overflow}, {3'b000, m_ovf});
  endtask

  task automatic model_step();
    bit         push = 0;
    int         ri = 0;
    logic [3:0] code;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (!m_down) begin
      if (m_run == 0) begin
        if (ROW == 4'hF) m_col = (m_col + 1) % 4;
        else if ($countones(~ROW) == 1) begin m_cand = ROW; m_run = 1; end
        else m_down = 1;
      end else if (ROW == m_cand) begin
        m_run++;
        if (m_run == DEB) begin push = 1; m_down = 1; m_run = 0; end
      end else begin
        m_run = 0;
      end
    end else begin
      if (ROW == 4'hF) begin
        m_run++;
        if (m_run == DEB) begin m_down = 0; m_run = 0; m_col = (m_col + 1) % 4; end
      end else begin
        m_run = 0;
      end
    end
    for (int r = 0; r < 4; r++) if (!m_cand[r]) ri = r;
    code = 4'(ri * 4 + m_col);
    if (m_q.size() != 0 && kif.key_ready) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) begin m_q.push_back(code); m_fresh = 0; end
      else m_ovf = 1;
    end
  endtask

  task automatic tick();
    ROW = rows_for(m_col);
    if (rdy_rand) kif.key_ready = 1'($urandom_range(0, 1));
    if (rdy_on_push) kif.key_ready = will_push();
    @(negedge newClock);
    check_outputs();
    model_step();
    @(posedge newClock);
    #1;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input int r, input int c, input int on_cyc, input int off_cyc);
    keys = 16'h0;
    keys[r*4+c] = 1'b1;
    hold(on_cyc);
    keys = 16'h0;
    hold(off_cyc);
  endtask

  initial begin
    reset_n = 1'b0;
    kif.key_ready = 1'b0;
    ROW = 4'hF;
    model_reset();
    @(posedge newClock);
    #1;
    hold(2);
    reset_n = 1'b1;
    kif.key_ready = 1'b1;
    hold(6);

    // clean press on row 2 / column 2
    press(2, 2, 20, 20);

    // press bounce then short release bounce
    keys = 16'h0;
    for (int i = 0; i < 15; i++) begin
      keys[1*4+3] = ((i / 3) % 2 == 0);
      tick();
    end
    keys[1*4+3] = 1'b1; hold(10);
    keys = 16'h0; hold(3);
    keys[1*4+3] = 1'b1; hold(2);
    keys = 16'h0; hold(4);
    keys[1*4+3] = 1'b1; hold(2);
    keys = 16'h0; hold(20);

    // ghost: rows 2 and 3 low in the same column
    keys = 16'h0;
    keys[2*4+1] = 1'b1;
    keys[3*4+1] = 1'b1;
    hold(12);
    keys = 16'h0; hold(20);

    // overflow with five distinct presses and no consumer
    kif.key_ready = 1'b0;
    press(0, 0, 20, 16);
    press(1, 1, 20, 16);
    press(2, 3, 20, 16);
    press(3, 2, 20, 16);
    press(0, 3, 20, 16);
    kif.key_ready = 1'b1;
    hold(10);

    // full FIFO with a pop exactly on the push cycle
    reset_n = 1'b0; hold(1); reset_n = 1'b1;
    kif.key_ready = 1'b0;
    press(3, 0, 20, 16);
    press(2, 1, 20, 16);
    press(1, 2, 20, 16);
    press(0, 1, 20, 16);
    rdy_on_push = 1;
    press(3, 3, 20, 16);
    rdy_on_push = 0;
    kif.key_ready = 1'b1;
    hold(8);

    // random presses, multi-key patterns, bounces and consumer stalls
    rdy_rand = 1;
    for (int it = 0; it < 40; it++) begin
      keys = 16'h0;
      keys[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 5) == 0) keys[$urandom_range(0, 15)] = 1'b1;
      if (it == 20) begin
        hold(5);
        reset_n = 1'b0; hold(1); reset_n = 1'b1;
      end
      for (int j = 0; j < 3; j++) begin
        hold($urandom_range(1, 25));
        if ($urandom_range(0, 2) == 0) begin
          logic [15:0] saved;
          saved = keys;
          keys = 16'h0;
          hold($urandom_range(1, 4));
          keys = saved;
        end
      end
      keys = 16'h0;
      hold($urandom_range(1, 25));
    end
    rdy_rand = 0;
    kif.key_ready = 1'b1;
    hold(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
